// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer for
// ADD, NOR, LW, SW and BEQ. It times out memory waits, flags illegal opcodes
// and counts retired instructions.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   start             begin fetch of the next instruction
//   opcode[OPW]       instruction opcode, sampled in DECODE
//   mem_ready         memory access complete (FETCH / MEM)
//   zero              ALU zero flag, used by BEQ in EXEC
//   pc_write ir_write mem_read mem_write reg_write reg_dst alu_src
//   branch_taken      datapath strobes
//   busy done         not idle / instruction completes this cycle
//   illegal timeout   sticky error flags, cleared when IDLE accepts start
//   alu_op[2]         00 add, 01 subtract, 10 nor
//   state[3]          current state code
//   retired[CNTW]     completed-instruction counter (wraps)
module multicycle_control #(
  parameter int unsigned    OPW    = 6,
  parameter logic [OPW-1:0] OP_ADD = 6'h00,
  parameter logic [OPW-1:0] OP_NOR = 6'h27,
  parameter logic [OPW-1:0] OP_LW  = 6'h23,
  parameter logic [OPW-1:0] OP_SW  = 6'h2B,
  parameter logic [OPW-1:0] OP_BEQ = 6'h04,
  parameter int unsigned    TMO    = 15,
  parameter int unsigned    CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  input  logic            zero,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            alu_src,
  output logic            branch_taken,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            timeout,
  output logic [1:0]      alu_op,
  output logic [2:0]      state,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [OPW-1:0]  r_op;
  logic [7:0]      r_wait;
  logic            r_illegal;
  logic            r_timeout;
  logic [CNTW-1:0] r_retired;

  logic w_add, w_nor, w_lw, w_sw, w_beq;
  logic w_legal, w_wait_exp, w_set_ill, w_set_tmo;

  assign w_add = (r_op == OP_ADD);
  assign w_nor = (r_op == OP_NOR);
  assign w_lw  = (r_op == OP_LW);
  assign w_sw  = (r_op == OP_SW);
  assign w_beq = (r_op == OP_BEQ);

  assign w_legal = (opcode == OP_ADD) || (opcode == OP_NOR) || (opcode == OP_LW) ||
                   (opcode == OP_SW)  || (opcode == OP_BEQ);

  // Counter holds the number of wait cycles already spent; this cycle is
  // wait cycle r_wait+1, so it is the last allowed one at TMO-1.
  assign w_wait_exp = !mem_ready && (r_wait == 8'(TMO - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_tmo = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready) w_next = S_DECODE;
        else if (w_wait_exp) begin
          w_next    = S_IDLE;
          w_set_tmo = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_legal) w_next = S_EXEC;
        else begin
          w_next    = S_IDLE;
          w_set_ill = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_beq) begin
          if (start) w_next = S_FETCH;
          else       w_next = S_IDLE;
        end else if (w_lw || w_sw) w_next = S_MEM;
        else                       w_next = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (w_lw)       w_next = S_WB;
          else if (start) w_next = S_FETCH;
          else            w_next = S_IDLE;
        end else if (w_wait_exp) begin
          w_next    = S_IDLE;
          w_set_tmo = 1'b1;
        end
      end
      S_WB: begin
        if (start) w_next = S_FETCH;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Op register, wait counter, sticky flags, retired counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_state == S_DECODE) r_op <= opcode;
      // Staying in a wait state means mem_ready was low; any entry clears it.
      if ((r_state == S_FETCH || r_state == S_MEM) && (w_next == r_state))
        r_wait <= r_wait + 8'd1;
      else
        r_wait <= '0;
      if (r_state == S_IDLE && start) begin
        r_illegal <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (w_set_ill) r_illegal <= 1'b1;
        if (w_set_tmo) r_timeout <= 1'b1;
      end
      if (done) r_retired <= r_retired + CNTW'(1);
    end
  end

  // Output decode. Only the FETCH write strobes and the SW completion are
  // qualified by mem_ready, and the BEQ branch strobes by zero.
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    alu_src      = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    alu_op       = 2'b00;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        if (w_beq) begin
          alu_op       = 2'b01;
          branch_taken = zero;
          pc_write     = zero;
          done         = 1'b1;
        end else if (w_nor) begin
          alu_op = 2'b10;
        end else if (w_lw || w_sw) begin
          alu_src = 1'b1;
        end
      end
      S_MEM: begin
        mem_read  = w_lw;
        mem_write = w_sw;
        done      = w_sw && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = w_add || w_nor;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Expected cycle traces are generated from
// the instruction-level rules (per-instruction phase lists with wait counts);
// a second instance with a 2-bit retired counter exercises wrap-around.
module tb_multicycle_control;
  localparam int TMO = 15;
  localparam int K_ADD = 0, K_NOR = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

  logic clk = 1'b0;
  logic reset_n, start, mem_ready, zero;
  logic [5:0] opcode;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src;
  logic branch_taken, busy, done, illegal, timeout;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [15:0] retired;
  logic [11:0] u2_bits;
  logic [1:0] u2_aop;
  logic [2:0] u2_st;
  logic [1:0] retired2;

  multicycle_control #(.TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .branch_taken(branch_taken),
    .busy(busy), .done(done), .illegal(illegal), .timeout(timeout),
    .alu_op(alu_op), .state(state), .retired(retired));

  multicycle_control #(.TMO(TMO), .CNTW(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero), .pc_write(u2_bits[0]), .ir_write(u2_bits[1]),
    .mem_read(u2_bits[2]), .mem_write(u2_bits[3]), .reg_write(u2_bits[4]),
    .reg_dst(u2_bits[5]), .alu_src(u2_bits[6]), .branch_taken(u2_bits[7]),
    .busy(u2_bits[8]), .done(u2_bits[9]), .illegal(u2_bits[10]), .timeout(u2_bits[11]),
    .alu_op(u2_aop), .state(u2_st), .retired(retired2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       mr;
    logic       z;
    logic [5:0] opc;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] aop;
    logic pcw, irw, mr, mw, rw, rd, asrc, bt, busy, done;
  } obs_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  obs_t  got_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_ret = 0;
  bit    exp_ill = 1'b0;
  bit    exp_tmo = 1'b0;

  function automatic obs_t blank(input int st);
    obs_t e;
    e      = '0;
    e.st   = 3'(st);
    e.busy = (st != 0);
    return e;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.start = 1'($urandom_range(0, 1));
    s.mr    = 1'($urandom_range(0, 1));
    s.z     = 1'($urandom_range(0, 1));
    s.opc   = 6'($urandom);
    return s;
  endfunction

  function automatic logic [5:0] op_of(input int kind);
    case (kind)
      K_ADD:   return 6'h00;
      K_NOR:   return 6'h27;
      K_LW:    return 6'h23;
      K_SW:    return 6'h2B;
      K_BEQ:   return 6'h04;
      default: return 6'h3F ^ 6'($urandom_range(0, 1));
    endcase
  endfunction

  // Instruction-level model: appends stimulus and the expected per-cycle
  // outputs. fwait/mwait = not-ready cycles before mem_ready; >= TMO means
  // that access never completes.
  task automatic model_instr(input int kind, input int fwait, input int mwait,
                             input logic z, input bit from_idle, input bit start_next);
    stim_t s;
    obs_t  e;
    if (from_idle) begin
      s = rnd_stim(); s.start = 1'b1;
      stim_q.push_back(s); exp_q.push_back(blank(0));
      exp_ill = 1'b0; exp_tmo = 1'b0;
    end
    for (int k = 0; k <= fwait && k < TMO; k++) begin
      s = rnd_stim(); s.mr = (k == fwait);
      e = blank(1); e.mr = 1'b1;
      if (k == fwait) begin e.irw = 1'b1; e.pcw = 1'b1; end
      stim_q.push_back(s); exp_q.push_back(e);
    end
    if (fwait >= TMO) begin exp_tmo = 1'b1; return; end
    s = rnd_stim(); s.opc = op_of(kind);
    stim_q.push_back(s); exp_q.push_back(blank(2));
    if (kind == K_ILL) begin exp_ill = 1'b1; return; end
    s = rnd_stim(); e = blank(3);
    case (kind)
      K_NOR: e.aop = 2'b10;
      K_LW, K_SW: e.asrc = 1'b1;
      K_BEQ: begin
        s.z = z; s.start = start_next;
        e.aop = 2'b01; e.bt = z; e.pcw = z; e.done = 1'b1;
        exp_ret++;
      end
      default: ;
    endcase
    stim_q.push_back(s); exp_q.push_back(e);
    if (kind == K_BEQ) return;
    if (kind == K_LW || kind == K_SW) begin
      for (int k = 0; k <= mwait && k < TMO; k++) begin
        s = rnd_stim(); s.mr = (k == mwait);
        e = blank(4); e.mr = (kind == K_LW); e.mw = (kind == K_SW);
        if (kind == K_SW && k == mwait) begin
          e.done = 1'b1; s.start = start_next; exp_ret++;
        end
        stim_q.push_back(s); exp_q.push_back(e);
      end
      if (mwait >= TMO) begin exp_tmo = 1'b1; return; end
      if (kind == K_SW) return;
    end
    s = rnd_stim(); s.start = start_next;
    e = blank(5); e.rw = 1'b1; e.rd = (kind != K_LW); e.done = 1'b1;
    exp_ret++;
    stim_q.push_back(s); exp_q.push_back(e);
  endtask

  // Drives n queued cycles (all if n < 0); called and returns at posedge+1.
  task automatic play(input int n);
    obs_t o;
    int   lim;
    lim = (n < 0) ? stim_q.size() : n;
    got_q.delete();
    for (int i = 0; i < lim; i++) begin
      start = stim_q[i].start; mem_ready = stim_q[i].mr;
      zero  = stim_q[i].z;     opcode    = stim_q[i].opc;
      @(negedge clk);
      o.st = state; o.aop = alu_op; o.pcw = pc_write; o.irw = ir_write;
      o.mr = mem_read; o.mw = mem_write; o.rw = reg_write; o.rd = reg_dst;
      o.asrc = alu_src; o.bt = branch_taken; o.busy = busy; o.done = done;
      if (o.st != 3'd3) begin o.aop = 2'b00; o.asrc = 1'b0; end
      if (o.st != 3'd5) o.rd = 1'b0;
      got_q.push_back(o);
      @(posedge clk); #1;
    end
    start = 1'b0; mem_ready = 1'b0; zero = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_ret = 0; exp_ill = 1'b0; exp_tmo = 1'b0;
    stim_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'h23;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src,
         branch_taken, busy, done, illegal, timeout, alu_op, state} !== '0) begin
      $display("FAIL reset_outputs got %b expected all zero",
               {pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, alu_src,
                branch_taken, busy, done, illegal, timeout, alu_op, state});
      errors++;
    end
    checks++;
    if (retired !== 16'd0) begin
      $display("FAIL reset_retired got %0d expected 0", retired); errors++;
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd1) begin
      $display("FAIL first_start got state %0d expected 1", state); errors++;
    end
    start = 1'b0;
  endtask

  task automatic test_lw();
    do_reset();
    model_instr(K_LW, 0, 0, 1'b0, 1'b1, 1'b0);
    play(-1);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL lw_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (retired !== 16'd1) begin
      $display("FAIL lw_retired got %0d expected 1", retired); errors++;
    end
  endtask

  task automatic test_beq();
    do_reset();
    model_instr(K_BEQ, 0, 0, 1'b1, 1'b1, 1'b0);
    model_instr(K_BEQ, 0, 0, 1'b0, 1'b1, 1'b0);
    play(-1);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL beq_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (retired !== 16'd2) begin
      $display("FAIL beq_retired got %0d expected 2", retired); errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    model_instr(K_ADD, 0, 0, 1'b0, 1'b1, 1'b1);
    model_instr(K_NOR, 0, 0, 1'b0, 1'b0, 1'b1);
    model_instr(K_SW,  0, 0, 1'b0, 1'b0, 1'b0);
    play(-1);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL b2b_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (retired !== 16'd3 || retired2 !== 2'd3) begin
      $display("FAIL b2b_retired got %0d/%0d expected 3/3", retired, retired2); errors++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    model_instr(K_LW, TMO, 0, 1'b0, 1'b1, 1'b0);
    play(-1);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL fetch_tmo_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (timeout !== 1'b1 || state !== 3'd0 || retired !== 16'd0) begin
      $display("FAIL fetch_tmo got tmo=%b st=%0d ret=%0d expected 1/0/0", timeout, state, retired);
      errors++;
    end
    stim_q.delete(); exp_q.delete();
    model_instr(K_ADD, TMO - 1, 0, 1'b0, 1'b1, 1'b0);
    play(-1);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL late_ready_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (timeout !== 1'b0 || retired !== 16'd1) begin
      $display("FAIL late_ready got tmo=%b ret=%0d expected 0/1", timeout, retired); errors++;
    end
    stim_q.delete(); exp_q.delete();
    model_instr(K_SW, 0, TMO, 1'b0, 1'b1, 1'b0);
    play(-1);
    checks++;
    if (timeout !== 1'b1 || state !== 3'd0 || retired !== 16'd1) begin
      $display("FAIL mem_tmo got tmo=%b st=%0d ret=%0d expected 1/0/1", timeout, state, retired);
      errors++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    model_instr(K_ILL, 1, 0, 1'b0, 1'b1, 1'b0);
    play(-1);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL ill_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (illegal !== 1'b1 || state !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL ill_sticky got ill=%b st=%0d busy=%b expected 1/0/0", illegal, state, busy);
      errors++;
    end
    stim_q.delete(); exp_q.delete();
    model_instr(K_NOR, 0, 0, 1'b0, 1'b1, 1'b0);
    play(-1);
    checks++;
    if (illegal !== 1'b0 || retired !== 16'd1) begin
      $display("FAIL ill_clear got ill=%b ret=%0d expected 0/1", illegal, retired); errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    model_instr(K_SW, 0, 5, 1'b0, 1'b1, 1'b0);
    play(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL mid_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    #2;
    checks++;
    if (mem_write !== 1'b1) begin
      $display("FAIL mid_pre got mem_write=%b expected 1", mem_write); errors++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state !== 3'd0 || done !== 1'b0 || retired !== 16'd0) begin
      $display("FAIL mid_abort got mw=%b st=%0d done=%b ret=%0d expected 0/0/0/0",
               mem_write, state, done, retired);
      errors++;
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || retired !== 16'd0) begin
      $display("FAIL mid_after got st=%0d ret=%0d expected 0/0", state, retired); errors++;
    end
    exp_ret = 0;
  endtask

  task automatic test_random();
    bit idle_next;
    int kind, fw, mw;
    bit sn;
    do_reset();
    idle_next = 1'b1;
    for (int n = 0; n < 50; n++) begin
      kind = ($urandom_range(0, 11) < 10) ? int'($urandom_range(0, 4)) : K_ILL;
      fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, TMO)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, TMO)) : int'($urandom_range(0, 3));
      sn = (n == 49) ? 1'b0 : 1'($urandom_range(0, 1));
      model_instr(kind, fw, mw, 1'($urandom_range(0, 1)), idle_next, sn);
      idle_next = !sn || kind == K_ILL || fw >= TMO ||
                  ((kind == K_LW || kind == K_SW) && mw >= TMO);
    end
    play(-1);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL rand_trace cycle %0d got %h expected %h", i, got_q[i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (retired !== 16'(exp_ret) || retired2 !== 2'(exp_ret)) begin
      $display("FAIL rand_retired got %0d/%0d expected %0d/%0d",
               retired, retired2, exp_ret, 2'(exp_ret));
      errors++;
    end
    checks++;
    if (illegal !== exp_ill || timeout !== exp_tmo) begin
      $display("FAIL rand_flags got ill=%b tmo=%b expected %b/%b", illegal, timeout, exp_ill, exp_tmo);
      errors++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
